// File: rtl/ysyx_041461_if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one doubleword fetch at a
// time and presents {valid, trap, inst, pc} to the ID pipeline register.
module ysyx_041461_if_stage #(
  parameter logic [63:0] RESET_PC       = 64'h0000_0000_3000_0000,
  parameter logic [3:0]  TRAP_NOP       = 4'd0,
  parameter logic [3:0]  TRAP_IMISALIGN = 4'd1,
  parameter logic [3:0]  TRAP_IFAULT    = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        if_valid,
  output logic [3:0]  if_trap,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc
);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StDrop
  } state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        misaligned;
  logic        handshake;

  // Request is issued only from REQ with a word-aligned PC; squashed during reset.
  always_comb begin
    misaligned     = (pc_q[1:0] != 2'b00);
    imem_req_valid = (state_q == StReq) && !misaligned && !rst;
    imem_req_addr  = {pc_q[63:3], 3'b000};
    handshake      = imem_req_valid && imem_req_ready;
  end

  // Fetch FSM with registered ID-facing outputs; redirect wins in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StReq;
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_trap  <= TRAP_NOP;
      if_inst  <= 32'd0;
      if_pc    <= RESET_PC;
    end else begin
      unique case (state_q)
        StReq: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            // An accepted request still owes us a response that must be dropped.
            state_q <= handshake ? StDrop : StReq;
          end else if (misaligned) begin
            state_q  <= StHold;
            if_valid <= 1'b1;
            if_trap  <= TRAP_IMISALIGN;
            if_inst  <= 32'd0;
            if_pc    <= pc_q;
          end else if (handshake) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= imem_resp_valid ? StReq : StDrop;
          end else if (imem_resp_valid) begin
            state_q  <= StHold;
            if_valid <= 1'b1;
            if_pc    <= pc_q;
            if (imem_resp_err) begin
              if_trap <= TRAP_IFAULT;
              if_inst <= 32'd0;
            end else begin
              if_trap <= TRAP_NOP;
              if_inst <= pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            end
          end
        end
        StHold: begin
          if (redirect_valid) begin
            pc_q     <= redirect_pc;
            if_valid <= 1'b0;
            state_q  <= StReq;
          end else if (id_ready) begin
            pc_q     <= pc_q + 64'd4;
            if_valid <= 1'b0;
            state_q  <= StReq;
          end
        end
        StDrop: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end
          if (imem_resp_valid) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_if_stage.sv
// Directed bench for the fetch stage: the memory side is driven by hand per scenario.
module tb_ysyx_041461_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        imem_resp_err;
  logic        if_valid;
  logic [3:0]  if_trap;
  logic [31:0] if_inst;
  logic [63:0] if_pc;

  int checks = 0;
  int errors = 0;

  ysyx_041461_if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_ready        (id_ready),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .if_valid        (if_valid),
    .if_trap         (if_trap),
    .if_inst         (if_inst),
    .if_pc           (if_pc)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a response for exactly one cycle.
  task automatic respond(input logic [63:0] data, input logic err);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 64'd0;
    imem_resp_err = 1'b0;
    step();
    step();
    checks++;
    if ({if_valid, if_trap, if_inst, if_pc} !== {1'b0, 4'd0, 32'd0, 64'h3000_0000}) begin
      errors++;
      $display("FAIL reset_out got %h want %h", {if_valid, if_trap, if_inst, if_pc},
               {1'b0, 4'd0, 32'd0, 64'h3000_0000});
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got %b want 0", imem_req_valid);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fetch();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h3000_0000}) begin
      errors++;
      $display("FAIL fetch_req0 got %h want %h", {imem_req_valid, imem_req_addr},
               {1'b1, 64'h3000_0000});
    end
    step();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait_noreq got %b want 0", imem_req_valid);
    end
    respond(64'h00000013_00100093, 1'b0);
    checks++;
    if ({if_valid, if_trap, if_inst, if_pc} !== {1'b1, 4'd0, 32'h0010_0093, 64'h3000_0000}) begin
      errors++;
      $display("FAIL fetch_out0 got %h want %h", {if_valid, if_trap, if_inst, if_pc},
               {1'b1, 4'd0, 32'h0010_0093, 64'h3000_0000});
    end
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 64'h3000_0000, 1'b0}) begin
      errors++;
      $display("FAIL fetch_req1 got %h want %h", {imem_req_valid, imem_req_addr, if_valid},
               {1'b1, 64'h3000_0000, 1'b0});
    end
    step();
    respond(64'h00000013_00100093, 1'b0);
    checks++;
    if ({if_valid, if_trap, if_inst, if_pc} !== {1'b1, 4'd0, 32'h0000_0013, 64'h3000_0004}) begin
      errors++;
      $display("FAIL fetch_out1 got %h want %h", {if_valid, if_trap, if_inst, if_pc},
               {1'b1, 4'd0, 32'h0000_0013, 64'h3000_0004});
    end
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h3000_0008}) begin
      errors++;
      $display("FAIL fetch_req2 got %h want %h", {imem_req_valid, imem_req_addr},
               {1'b1, 64'h3000_0008});
    end
  endtask

  // Enters in REQ at pc 0x30000008.
  task automatic test_stall();
    id_ready = 1'b0;
    step();
    respond(64'h11111111_22222222, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({if_valid, if_inst, if_pc, imem_req_valid} !==
          {1'b1, 32'h2222_2222, 64'h3000_0008, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d got %h want %h", i,
                 {if_valid, if_inst, if_pc, imem_req_valid},
                 {1'b1, 32'h2222_2222, 64'h3000_0008, 1'b0});
      end
      step();
    end
    id_ready = 1'b1;
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 64'h3000_0008, 1'b0}) begin
      errors++;
      $display("FAIL stall_release got %h want %h", {imem_req_valid, imem_req_addr, if_valid},
               {1'b1, 64'h3000_0008, 1'b0});
    end
  endtask

  // Enters in REQ at pc 0x3000000C.
  task automatic test_redirect_wait();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0010;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({imem_req_valid, if_valid} !== 2'b00) begin
        errors++;
        $display("FAIL drop_idle%0d got %b want 00", i, {imem_req_valid, if_valid});
      end
      step();
    end
    respond(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    checks++;
    if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 64'h8000_0010, 1'b0}) begin
      errors++;
      $display("FAIL drop_req got %h want %h", {imem_req_valid, imem_req_addr, if_valid},
               {1'b1, 64'h8000_0010, 1'b0});
    end
    step();
    respond(64'hAAAA_AAAA_0000_0513, 1'b0);
    checks++;
    if ({if_valid, if_trap, if_inst, if_pc} !== {1'b1, 4'd0, 32'h0000_0513, 64'h8000_0010}) begin
      errors++;
      $display("FAIL drop_out got %h want %h", {if_valid, if_trap, if_inst, if_pc},
               {1'b1, 4'd0, 32'h0000_0513, 64'h8000_0010});
    end
  endtask

  // Enters in HOLD.
  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0002;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req_valid, if_valid} !== 2'b00) begin
      errors++;
      $display("FAIL misalign_noreq got %b want 00", {imem_req_valid, if_valid});
    end
    step();
    checks++;
    if ({if_valid, if_trap, if_inst, if_pc, imem_req_valid} !==
        {1'b1, 4'd1, 32'd0, 64'h8000_0002, 1'b0}) begin
      errors++;
      $display("FAIL misalign_out got %h want %h", {if_valid, if_trap, if_inst, if_pc, imem_req_valid},
               {1'b1, 4'd1, 32'd0, 64'h8000_0002, 1'b0});
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000_0004;
    step();
    redirect_valid = 1'b0;
  endtask

  // Enters in REQ at pc 0x30000004.
  task automatic test_ifault();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h3000_0000}) begin
      errors++;
      $display("FAIL ifault_req got %h want %h", {imem_req_valid, imem_req_addr},
               {1'b1, 64'h3000_0000});
    end
    step();
    respond(64'h1234_5678_1234_5678, 1'b1);
    checks++;
    if ({if_valid, if_trap, if_inst, if_pc} !== {1'b1, 4'd2, 32'd0, 64'h3000_0004}) begin
      errors++;
      $display("FAIL ifault_out got %h want %h", {if_valid, if_trap, if_inst, if_pc},
               {1'b1, 4'd2, 32'd0, 64'h3000_0004});
    end
    step();
  endtask

  // Enters in REQ at pc 0x30000008.
  task automatic test_redirect_corners();
    // Redirect coinciding with a response in WAIT.
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data = 64'h5555_5555_5555_5555;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0020;
    step();
    imem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 64'h8000_0020, 1'b0}) begin
      errors++;
      $display("FAIL redir_resp got %h want %h", {imem_req_valid, imem_req_addr, if_valid},
               {1'b1, 64'h8000_0020, 1'b0});
    end
    step();
    respond(64'h1234_5678_9ABC_DEF0, 1'b0);
    checks++;
    if ({if_valid, if_inst, if_pc} !== {1'b1, 32'h9ABC_DEF0, 64'h8000_0020}) begin
      errors++;
      $display("FAIL redir_resp_out got %h want %h", {if_valid, if_inst, if_pc},
               {1'b1, 32'h9ABC_DEF0, 64'h8000_0020});
    end
    // Redirect coinciding with id_ready in HOLD.
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0104;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 64'h8000_0100, 1'b0}) begin
      errors++;
      $display("FAIL redir_hold got %h want %h", {imem_req_valid, imem_req_addr, if_valid},
               {1'b1, 64'h8000_0100, 1'b0});
    end
    step();
    respond(64'hCAFE_F00D_0BAD_C0DE, 1'b0);
    checks++;
    if ({if_valid, if_inst, if_pc} !== {1'b1, 32'hCAFE_F00D, 64'h8000_0104}) begin
      errors++;
      $display("FAIL redir_hold_out got %h want %h", {if_valid, if_inst, if_pc},
               {1'b1, 32'hCAFE_F00D, 64'h8000_0104});
    end
    // Redirect in REQ while the request is accepted: response must be dropped.
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0040;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req_valid, if_valid} !== 2'b00) begin
      errors++;
      $display("FAIL redir_req_drop got %b want 00", {imem_req_valid, if_valid});
    end
    respond(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    checks++;
    if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 64'h8000_0040, 1'b0}) begin
      errors++;
      $display("FAIL redir_req_next got %h want %h", {imem_req_valid, imem_req_addr, if_valid},
               {1'b1, 64'h8000_0040, 1'b0});
    end
  endtask

  // Enters in REQ at pc 0x80000040.
  task automatic test_reset_midfetch();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({if_valid, if_pc, imem_req_valid} !== {1'b0, 64'h3000_0000, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid got %h want %h", {if_valid, if_pc, imem_req_valid},
               {1'b0, 64'h3000_0000, 1'b0});
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h3000_0000}) begin
      errors++;
      $display("FAIL rst_mid_req got %h want %h", {imem_req_valid, imem_req_addr},
               {1'b1, 64'h3000_0000});
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_misalign();
    test_ifault();
    test_redirect_corners();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_041461_if_stage.md
Name: ysyx_041461_IF_stage

Overview:
Instruction-fetch stage of the RV64 in-order pipeline. Holds the architectural fetch PC and issues one 64-bit instruction-memory request at a time. It extracts the 32-bit instruction from each response and presents {valid, trap, inst, pc} to the ID pipeline register. Redirects from later stages (branch, jump, trap entry) flush any fetch in flight. Stalls are honoured through the downstream enable.

Parameters:
RESET_PC, 64'h0000_0000_3000_0000, fetch PC after reset
TRAP_NOP, 4'd0, trap code for a normal instruction
TRAP_IMISALIGN, 4'd1, trap code for an instruction-address-misaligned fetch
TRAP_IFAULT, 4'd2, trap code for an instruction access fault

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
redirect_valid  in  1  flush and redirect fetch this cycle
redirect_pc  in  64  new fetch PC
id_ready  in  1  ID register enable; 1 = consumes if_* this cycle
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  64  doubleword-aligned address, pc & ~64'h7
imem_req_ready  in  1  memory accepts the request
imem_resp_valid  in  1  response valid; at most one outstanding
imem_resp_data  in  64  response doubleword
imem_resp_err  in  1  access error on this response
if_valid  out  1  fetched entry valid for ID
if_trap  out  4  trap code of the entry
if_inst  out  32  instruction word
if_pc  out  64  PC of the entry

Behaviour:
- Reset (async): state=REQ; pc=RESET_PC; if_valid=0; if_trap=TRAP_NOP; if_inst=0; if_pc=RESET_PC; imem_req_valid=0 while rst is high.
- States: REQ, WAIT, HOLD, DROP. Request handshake = imem_req_valid & imem_req_ready.
- REQ:
  - If pc[1:0]!=0: no request is issued. Next state HOLD with if_trap=TRAP_IMISALIGN, if_inst=0, if_pc=pc.
  - Otherwise imem_req_valid=1 and imem_req_addr=pc & ~7. On handshake, go to WAIT.
- WAIT: on imem_resp_valid, go to HOLD and latch if_pc=pc.
  - If imem_resp_err=1: if_trap=TRAP_IFAULT, if_inst=0.
  - Else: if_trap=TRAP_NOP, if_inst = pc[2] ? data[63:32] : data[31:0].
- HOLD: if_valid=1 and the if_* outputs are held stable. When id_ready=1: pc<=pc+4 (64-bit wrap), if_valid<=0 next cycle, go to REQ. When id_ready=0: stay in HOLD with outputs unchanged.
- if_valid is 1 only in HOLD. Minimum fetch-to-valid latency is 2 cycles: request accepted in cycle N, response no earlier than N+1, if_valid=1 in the cycle after the response.
- Redirect (highest priority, every state). The next-cycle pc is always redirect_pc.
  - REQ, no handshake this cycle: stay in REQ. The request address changes to the new pc next cycle; retracting or changing an unaccepted request is legal on this interface.
  - REQ with handshake in the same cycle: go to DROP.
  - WAIT with no response this cycle: go to DROP.
  - WAIT with a response this cycle: discard the response and go to REQ.
  - HOLD: if_valid<=0 and go to REQ, regardless of id_ready.
  - DROP: stay in DROP, or go to REQ if the response arrives this cycle.
- DROP: imem_req_valid=0. Wait for imem_resp_valid, discard data and err, then go to REQ.
- A response arriving in REQ or HOLD is a protocol violation. It is ignored; an optional assertion fires.
- Reset asserted mid-fetch abandons the outstanding request. The memory side is reset by the same rst.

Test Plan:
- Reset release; memory returns data=64'h00000013_00100093 one cycle after each handshake; id_ready=1 → addresses 0x30000000 then 0x30000000; if_inst=0x00100093 at pc 0x30000000, then 0x00000013 at 0x30000004; next request addr 0x30000008.
- id_ready=0 for 5 cycles while in HOLD → if_valid stays 1, if_pc/if_inst constant, no imem_req_valid; release → next request issued the following cycle.
- Redirect to 0x80000010 in WAIT, response arrives 3 cycles later with data X → response discarded, no if_valid; next request addr 0x80000010, inst taken from data[31:0].
- Redirect to 0x80000002 → no memory request; if_valid=1, if_trap=TRAP_IMISALIGN, if_inst=0, if_pc=0x80000002.
- imem_resp_err=1 on a fetch at 0x30000004 → if_trap=TRAP_IFAULT, if_inst=0, if_pc=0x30000004.
- Redirect in the same cycle as a response in WAIT, and in the same cycle as id_ready in HOLD → both take the redirect: if_valid=0 next cycle, REQ at redirect_pc; rst pulsed during WAIT → pc=0x30000000, if_valid=0 immediately.
